// File: rtl/io_hub_pkg.sv
// io_hub_pkg: constants and UART FSM encoding shared by the I/O Hub tx and rx stages.
package io_hub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam int   BYTES_PER_WORD = 4;

  // 50 MHz system clock / 115200 baud
  localparam int UART_CLK_DIV_DEFAULT = 434;

endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: synchronous DATA_W x DEPTH word FIFO with show-ahead read data.
module io_tx_fifo
  import io_hub_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointers wrap naturally; DEPTH is a power of two.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: buffers 32-bit words and sends them as 4 UART frames, LSB byte first.
// Build option IO_UART_TX_PARITY_EN adds an even parity bit (8E1); default is 8N1.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered word
// START  | start bit, line low
// DATA   | 8 data bits, LSB first
// PARITY | even parity of the byte (parity builds only)
// STOP   | stop bit, then next byte, next word, or idle
module io_uart_tx
  import io_hub_pkg::*;
#(
  parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              word_vld_i,
  output logic              word_rdy_o,
  input  logic [DATA_W-1:0] word_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              fifo_full_o,
  output logic              fifo_empty_o
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  BAUD_LAST = CW'(CLK_DIV - 1);
  localparam logic [1:0]     LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_tick;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rd_data;
`ifdef IO_UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  io_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .push_i    (word_vld_i),
    .wr_data_i (word_i),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full_o),
    .empty_o   (fifo_empty_o)
  );

  assign baud_tick  = (baud_q == BAUD_LAST);
  assign word_rdy_o = !fifo_full_o;
  assign busy_o     = (state_q != ST_IDLE) || !fifo_empty_o;
  assign tx_o       = tx_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
`ifdef IO_UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    if (state_q != ST_IDLE) baud_d = baud_tick ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_o) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          byte_d   = '0;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          bit_d   = '0;
          state_d = ST_DATA;
`ifdef IO_UART_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        // Shifting right leaves the next byte in shift_q[7:0] after 8 bits.
        if (baud_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
`ifdef IO_UART_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
          if (bit_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
      ST_PARITY: begin
        if (baud_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (byte_q != LAST_BYTE) begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_START;
          end else if (!fifo_empty_o) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            byte_d   = '0;
            state_d  = ST_START;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the current state one cycle later (registered output).
  always_comb begin
    tx_d = UART_IDLE_LVL;
    case (state_q)
      ST_START:  tx_d = UART_START_LVL;
      ST_DATA:   tx_d = shift_q[0];
`ifdef IO_UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      default:   tx_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shift_q <= '0;
      tx_q    <= UART_IDLE_LVL;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef IO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: scoreboard bench for io_uart_tx; one instance at CLK_DIV=4, one at CLK_DIV=2.
module tb_io_uart_tx;

  localparam int D1 = 4;
  localparam int D2 = 2;
`ifdef IO_UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int WORD1 = 4 * FBITS * D1;
  localparam int WORD2 = 4 * FBITS * D2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld1  = 1'b0;
  logic        vld2  = 1'b0;
  logic [31:0] wd1   = '0;
  logic [31:0] wd2   = '0;
  logic        rdy1, tx1, busy1, full1, empty1;
  logic        rdy2, tx2, busy2, full2, empty2;

  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp1_q[$];
  logic [7:0]  exp2_q[$];
  int          starts1[$];
  bit          mon_en1  = 1'b0;
  bit          mon_en2  = 1'b0;

  typedef struct {
    logic [31:0] word;
    bit          exp_acc;
    bit          exp_full;
  } vec_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  io_uart_tx #(.CLK_DIV(D1), .FIFO_DEPTH(4), .DATA_W(32)) u_dut (
    .sys_clk      (clk),
    .sys_rst      (rst_n),
    .word_vld_i   (vld1),
    .word_rdy_o   (rdy1),
    .word_i       (wd1),
    .tx_o         (tx1),
    .busy_o       (busy1),
    .fifo_full_o  (full1),
    .fifo_empty_o (empty1)
  );

  io_uart_tx #(.CLK_DIV(D2), .FIFO_DEPTH(4), .DATA_W(32)) u_dut2 (
    .sys_clk      (clk),
    .sys_rst      (rst_n),
    .word_vld_i   (vld2),
    .word_rdy_o   (rdy2),
    .word_i       (wd2),
    .tx_o         (tx2),
    .busy_o       (busy2),
    .fifo_full_o  (full2),
    .fifo_empty_o (empty2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx1 : tx2;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy1 : busy2;
  endfunction

  // Called at a negedge; drives one push across the next rising edge.
  task automatic push(input int sel, input logic [31:0] w, input bit scb, output bit acc);
    if (sel == 0) begin
      vld1 = 1'b1; wd1 = w; acc = rdy1;
    end else begin
      vld2 = 1'b1; wd2 = w; acc = rdy2;
    end
    if (acc && scb) begin
      for (int i = 0; i < 4; i++) begin
        if (sel == 0) exp1_q.push_back(w[8*i +: 8]);
        else          exp2_q.push_back(w[8*i +: 8]);
      end
    end
    @(negedge clk);
    vld1 = 1'b0;
    vld2 = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input int max, input string name, output int drop);
    int n;
    n = 0;
    while (busy_of(sel) !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    drop = cyc;
    check({name, "_idle_in_time"}, busy_of(sel), 1'b0);
    repeat (3) @(negedge clk);
  endtask

  // Entered on the first low sample of a start bit; checks every cycle of the frame.
  task automatic rx_frame(input int sel, input int div, output logic [7:0] b, output bit ok);
    logic v;
    ok = 1'b1;
    b  = '0;
    for (int c = 1; c < div; c++) begin
      @(negedge clk);
      if (tx_of(sel) !== 1'b0) ok = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v    = tx_of(sel);
      b[i] = v;
      for (int c = 1; c < div; c++) begin
        @(negedge clk);
        if (tx_of(sel) !== v) ok = 1'b0;
      end
    end
`ifdef IO_UART_TX_PARITY_EN
    @(negedge clk);
    v = tx_of(sel);
    if (v !== ^b) ok = 1'b0;
    for (int c = 1; c < div; c++) begin
      @(negedge clk);
      if (tx_of(sel) !== v) ok = 1'b0;
    end
`endif
    for (int c = 0; c < div; c++) begin
      @(negedge clk);
      if (tx_of(sel) !== 1'b1) ok = 1'b0;
    end
  endtask

  initial begin : mon1
    logic [7:0] b, e;
    bit         ok, have;
    forever begin
      @(negedge clk);
      if (mon_en1 && tx1 === 1'b0) begin
        starts1.push_back(cyc);
        have = (exp1_q.size() != 0);
        e    = have ? exp1_q.pop_front() : 8'h00;
        rx_frame(0, D1, b, ok);
        check("frame_shape_d4", ok, 1'b1);
        check("frame_expected_d4", have, 1'b1);
        if (have) check("frame_byte_d4", b, e);
      end
    end
  end

  initial begin : mon2
    logic [7:0] b, e;
    bit         ok, have;
    forever begin
      @(negedge clk);
      if (mon_en2 && tx2 === 1'b0) begin
        have = (exp2_q.size() != 0);
        e    = have ? exp2_q.pop_front() : 8'h00;
        rx_frame(1, D2, b, ok);
        check("frame_shape_d2", ok, 1'b1);
        check("frame_expected_d2", have, 1'b1);
        if (have) check("frame_byte_d2", b, e);
      end
    end
  end

  initial begin : watchdog
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[6];
    bit   acc;
    int   k, idx, drop, n, s, lows;

    vecs[0] = '{word: 32'h0781_0781, exp_acc: 1'b1, exp_full: 1'b0};
    vecs[1] = '{word: 32'h1234_5678, exp_acc: 1'b1, exp_full: 1'b0};
    vecs[2] = '{word: 32'hFFFF_FFFF, exp_acc: 1'b1, exp_full: 1'b0};
    vecs[3] = '{word: 32'h0000_0000, exp_acc: 1'b1, exp_full: 1'b0};
    vecs[4] = '{word: 32'hDEAD_BEEF, exp_acc: 1'b1, exp_full: 1'b1};
    vecs[5] = '{word: 32'hCAFE_F00D, exp_acc: 1'b0, exp_full: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_tx",    tx1,    1'b1);
    check("rst_busy",  busy1,  1'b0);
    check("rst_rdy",   rdy1,   1'b1);
    check("rst_empty", empty1, 1'b1);
    check("rst_full",  full1,  1'b0);
    check("rst_tx2",   tx2,    1'b1);
    check("rst_busy2", busy2,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en1 = 1'b1;
    mon_en2 = 1'b1;

    // Single word: start bit two edges after the push edge, word length, busy drop.
    idx = starts1.size();
    k   = cyc;
    push(0, 32'hA5C3_0F81, 1'b1, acc);
    check("t1_accept", acc, 1'b1);
    wait_idle(0, WORD1 + 50, "t1", drop);
    check("t1_frames", starts1.size() - idx, 4);
    if (starts1.size() > idx) check("t1_latency", starts1[idx] - (k + 1), 2);
    check("t1_busy_drop", drop - (k + 1), 1 + WORD1);

    // Six back-to-back pushes: five fit (four in FIFO, one in the shifter).
    idx = starts1.size();
    k   = cyc;
    for (int i = 0; i < 6; i++) begin
      push(0, vecs[i].word, 1'b1, acc);
      check("t2_accept", acc, vecs[i].exp_acc);
      check("t2_full", full1, vecs[i].exp_full);
      check("t2_rdy", rdy1, !vecs[i].exp_full);
      check("t2_empty", empty1, 1'b0);
    end
    n = 0;
    while (rdy1 !== 1'b1 && n < 2 * WORD1) begin
      @(negedge clk);
      n++;
    end
    check("t2_rdy_rise", cyc - k, 2 + WORD1);
    wait_idle(0, 6 * WORD1, "t2", drop);

    // Queued words run with no idle gap, including across the word boundary.
    check("t3_frames", starts1.size() - idx, 20);
    for (int j = idx; j < idx + 19; j++) begin
      if (j + 1 < starts1.size()) check("t3_gap", starts1[j+1] - starts1[j], FBITS * D1);
    end

    // Reset during bit 3 of byte 1 with a second word waiting in the FIFO.
    mon_en1 = 1'b0;
    push(0, 32'h5A5A_F000, 1'b0, acc);
    push(0, 32'h1234_5678, 1'b0, acc);
    n = 0;
    while (tx1 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    s = cyc;
    check("t4_frame_started", tx1, 1'b0);
    while (cyc < s + FBITS * D1 + 4 * D1 + 1) @(negedge clk);
    check("t4_mid_bit_low", tx1, 1'b0);
    check("t4_busy_before", busy1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_tx",    tx1,    1'b1);
    check("t4_rst_empty", empty1, 1'b1);
    check("t4_rst_busy",  busy1,  1'b0);
    check("t4_rst_rdy",   rdy1,   1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lows  = 0;
    repeat (2 * WORD1) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) lows++;
    end
    check("t4_no_residual", lows, 0);
    mon_en1 = 1'b1;
    idx     = starts1.size();
    push(0, 32'h3C3C_0F0F, 1'b1, acc);
    check("t4_accept", acc, 1'b1);
    wait_idle(0, WORD1 + 50, "t4", drop);
    check("t4_clean_frames", starts1.size() - idx, 4);

    // CLK_DIV=2: push lands on the same edge as a pop with two words stored.
    k = cyc;
    push(1, 32'h1122_3344, 1'b1, acc);
    push(1, 32'h5566_7788, 1'b1, acc);
    push(1, 32'h99AA_BBCC, 1'b1, acc);
    check("t6_empty_pre", empty2, 1'b0);
    check("t6_full_pre",  full2,  1'b0);
    while (cyc < k + 1 + WORD2) @(negedge clk);
    push(1, 32'hDDEE_FF00, 1'b1, acc);
    check("t6_accept_on_pop", acc, 1'b1);
    check("t6_empty_after", empty2, 1'b0);
    check("t6_full_after",  full2,  1'b0);
    push(1, 32'h0F1E_2D3C, 1'b1, acc);
    check("t6_full_3", full2, 1'b0);
    push(1, 32'h4B5A_6978, 1'b1, acc);
    check("t6_full_4", full2, 1'b1);
    wait_idle(1, 8 * WORD2, "t6", drop);

    check("end_q1_empty", exp1_q.size(), 0);
    check("end_q2_empty", exp2_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
